// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, state encoding and bin-field helpers for the FFT peak detector
package fft_pkg;

  localparam int N_BINS         = 16;
  localparam int BIN_IDX_W      = 4;
  localparam int DATA_W         = 32;
  localparam int RE_MSB         = 31;
  localparam int RE_LSB         = 16;
  localparam int IM_MSB         = 15;
  localparam int IM_LSB         = 0;
  localparam int DEFAULT_FRAMES = 64;
  localparam int ABS_MAG_W      = 17;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef logic [DATA_W-1:0] bin_word_t;

  function automatic logic signed [15:0] bin_re(input bin_word_t w);
    return w[RE_MSB:RE_LSB];
  endfunction

  function automatic logic signed [15:0] bin_im(input bin_word_t w);
    return w[IM_MSB:IM_LSB];
  endfunction

endpackage

// File: rtl/fft_bin_mag.sv
// rtl/fft_bin_mag.sv - combinational bin magnitude; FFT_PEAK_MAG_ABS_EN selects |re|+|im| over re^2+im^2
module fft_bin_mag
  import fft_pkg::*;
#(
  parameter int MAG_W = 33
) (
  input  logic [DATA_W-1:0] word,
  output logic [MAG_W-1:0]  mag
);

  logic signed [15:0] re;
  logic signed [15:0] im;

  assign re = bin_re(word);
  assign im = bin_im(word);

`ifdef FFT_PEAK_MAG_ABS_EN
  // 17 bits so that |-32768| and the full sum both fit
  logic [16:0] re_abs;
  logic [16:0] im_abs;

  assign re_abs = re[15] ? (17'd0 - {re[15], re}) : {1'b0, re};
  assign im_abs = im[15] ? (17'd0 - {im[15], im}) : {1'b0, im};
  assign mag    = MAG_W'(re_abs + im_abs);
`else
  logic signed [31:0] re_x;
  logic signed [31:0] im_x;
  logic signed [31:0] re_sq;
  logic signed [31:0] im_sq;
  logic [32:0]        sq_sum;

  assign re_x   = 32'(re);
  assign im_x   = 32'(im);
  assign re_sq  = re_x * re_x;
  assign im_sq  = im_x * im_x;
  assign sq_sum = {1'b0, re_sq} + {1'b0, im_sq};
  assign mag    = MAG_W'(sq_sum);
`endif

endmodule

// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - per-frame peak-bin search with frame counting; FFT_PEAK_MAG_ABS_EN selects abs magnitude
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int FRAMES = DEFAULT_FRAMES,
  parameter int MAG_W  = 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fft_valid,
  input  logic signed [31:0] fft_d0,
  input  logic signed [31:0] fft_d1,
  input  logic signed [31:0] fft_d2,
  input  logic signed [31:0] fft_d3,
  input  logic signed [31:0] fft_d4,
  input  logic signed [31:0] fft_d5,
  input  logic signed [31:0] fft_d6,
  input  logic signed [31:0] fft_d7,
  input  logic signed [31:0] fft_d8,
  input  logic signed [31:0] fft_d9,
  input  logic signed [31:0] fft_d10,
  input  logic signed [31:0] fft_d11,
  input  logic signed [31:0] fft_d12,
  input  logic signed [31:0] fft_d13,
  input  logic signed [31:0] fft_d14,
  input  logic signed [31:0] fft_d15,
  output logic [3:0]         freq,
  output logic               freq_valid,
  output logic               done,
  output logic               overrun
);

`ifdef FFT_PEAK_MAG_ABS_EN
  localparam int M_W = ABS_MAG_W;
`else
  localparam int M_W = MAG_W;
`endif
  localparam int CNT_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  bin_word_t            din    [N_BINS];
  bin_word_t            bins_q [N_BINS];
  state_t               state, next_state;
  logic [BIN_IDX_W-1:0] idx;
  logic [BIN_IDX_W-1:0] arg_q;
  logic [BIN_IDX_W-1:0] final_arg;
  logic [M_W-1:0]       mag;
  logic [M_W-1:0]       max_q;
  logic [CNT_W-1:0]     frame_cnt;
  logic                 last_bin;
  logic                 accept;
  logic                 better;

  assign din[0]  = fft_d0;
  assign din[1]  = fft_d1;
  assign din[2]  = fft_d2;
  assign din[3]  = fft_d3;
  assign din[4]  = fft_d4;
  assign din[5]  = fft_d5;
  assign din[6]  = fft_d6;
  assign din[7]  = fft_d7;
  assign din[8]  = fft_d8;
  assign din[9]  = fft_d9;
  assign din[10] = fft_d10;
  assign din[11] = fft_d11;
  assign din[12] = fft_d12;
  assign din[13] = fft_d13;
  assign din[14] = fft_d14;
  assign din[15] = fft_d15;

  fft_bin_mag #(.MAG_W(M_W)) u_mag (
    .word (bins_q[idx]),
    .mag  (mag)
  );

  // Bin 0 seeds the running max; strict compare keeps the lowest index on ties
  assign better    = (idx == '0) || (mag > max_q);
  assign final_arg = better ? idx : arg_q;

  always_comb begin
    next_state = state;
    last_bin   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (fft_valid) begin
          accept     = 1'b1;
          next_state = SCAN;
        end
      end
      SCAN: begin
        if (idx == BIN_IDX_W'(N_BINS - 1)) begin
          last_bin   = 1'b1;
          accept     = fft_valid;
          next_state = fft_valid ? SCAN : IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      max_q      <= '0;
      arg_q      <= '0;
      freq       <= '0;
      freq_valid <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      frame_cnt  <= '0;
      for (int i = 0; i < N_BINS; i++) bins_q[i] <= '0;
    end else begin
      freq_valid <= last_bin;
      done       <= last_bin && (frame_cnt == CNT_W'(FRAMES - 1));

      // Bin 15 is read combinationally before this edge overwrites the buffer
      if (accept) bins_q <= din;

      if (state == SCAN && better) begin
        max_q <= mag;
        arg_q <= idx;
      end

      if (accept)             idx <= '0;
      else if (state == SCAN) idx <= idx + 1'b1;

      if (last_bin) begin
        freq      <= final_arg;
        frame_cnt <= (frame_cnt == CNT_W'(FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
      end

      if (fft_valid && state == SCAN && !last_bin) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb/tb_fft_peak_detect.sv - scoreboard bench for fft_peak_detect (FRAMES=4)
module tb_fft_peak_detect;

  localparam int FR = 4;

  typedef logic [31:0] frame_t [16];
  typedef struct packed {
    logic [3:0]  freq;
    logic        done;
    logic [31:0] cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fft_valid;
  frame_t      d_in;
  logic [3:0]  freq;
  logic        freq_valid;
  logic        done;
  logic        overrun;
  logic [31:0] cyc = '0;

  res_t exp_q[$];
  res_t obs_q[$];
  res_t e, o;
  int   checks = 0;
  int   errors = 0;
  int   res_cnt = 0;

  fft_peak_detect #(.FRAMES(FR), .MAG_W(33)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d_in[0]),   .fft_d1(d_in[1]),   .fft_d2(d_in[2]),   .fft_d3(d_in[3]),
    .fft_d4(d_in[4]),   .fft_d5(d_in[5]),   .fft_d6(d_in[6]),   .fft_d7(d_in[7]),
    .fft_d8(d_in[8]),   .fft_d9(d_in[9]),   .fft_d10(d_in[10]), .fft_d11(d_in[11]),
    .fft_d12(d_in[12]), .fft_d13(d_in[13]), .fft_d14(d_in[14]), .fft_d15(d_in[15]),
    .freq(freq), .freq_valid(freq_valid), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (freq_valid) obs_q.push_back('{freq: freq, done: done, cyc: cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic frame_t tone(input int k, input logic [31:0] w);
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = '0;
    f[k] = w;
    return f;
  endfunction

  // One-cycle frame strobe; expected result is scheduled 17 cycles later
  task automatic send(input frame_t f, input logic [3:0] exp_freq, input bit exp_result);
    res_t r;
    d_in      = f;
    fft_valid = 1'b1;
    if (exp_result) begin
      res_cnt++;
      r.freq = exp_freq;
      r.done = (res_cnt == FR);
      r.cyc  = cyc + 17;
      if (res_cnt == FR) res_cnt = 0;
      exp_q.push_back(r);
    end
    tick(1);
    fft_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fft_valid = 1'b0;
    for (int i = 0; i < 16; i++) d_in[i] = '0;
    tick(2);
    checks++; if (freq !== 4'd0)       begin errors++; $display("FAIL reset_freq: got %0d, expected 0", freq); end
    checks++; if (freq_valid !== 1'b0) begin errors++; $display("FAIL reset_freq_valid: got %b, expected 0", freq_valid); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single_tone();
    send(tone(5, {16'sd1000, 16'sd0}), 4'd5, 1'b1);
    wait_results(1, 40);
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL single_tone: no freq_valid, expected freq=%0d at cycle %0d", e.freq, e.cyc); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL single_tone: got freq=%0d done=%0d cyc=%0d, expected freq=%0d done=%0d cyc=%0d", o.freq, o.done, o.cyc, e.freq, e.done, e.cyc); end
    end
    tick(3);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL single_tone_extra: got %0d extra results, expected 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_tie();
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = {16'sd1, 16'sd1};
    f[3] = {-16'sd300, 16'sd400};
    f[9] = {16'sd500, 16'sd0};
    send(f, 4'd3, 1'b1);
    wait_results(1, 40);
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL tie: no freq_valid, expected freq=%0d", e.freq); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL tie: got freq=%0d done=%0d cyc=%0d, expected freq=%0d done=%0d cyc=%0d", o.freq, o.done, o.cyc, e.freq, e.done, e.cyc); end
    end
  endtask

  task automatic test_back_to_back();
    send(tone(2, {16'sd700, 16'sd0}), 4'd2, 1'b1);
    tick(15);
    send(tone(15, {16'sd0, -16'sd2000}), 4'd15, 1'b1);
    tick(15);
    send(tone(0, {-16'sd900, 16'sd50}), 4'd0, 1'b1);
    wait_results(3, 80);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL back_to_back[%0d]: no freq_valid, expected freq=%0d", i, e.freq); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL back_to_back[%0d]: got freq=%0d done=%0d cyc=%0d, expected freq=%0d done=%0d cyc=%0d", i, o.freq, o.done, o.cyc, e.freq, e.done, e.cyc); end
      end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL back_to_back_overrun: got %b, expected 0", overrun); end
  endtask

  task automatic test_run_end();
    logic [3:0] peaks [5];
    peaks[0] = 4'd1; peaks[1] = 4'd4; peaks[2] = 4'd8; peaks[3] = 4'd12; peaks[4] = 4'd6;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    res_cnt = 0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      send(tone(int'(peaks[i]), {16'sd123, 16'sd456}), peaks[i], 1'b1);
      if (i < 4) tick(15);
    end
    wait_results(5, 120);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL run_end[%0d]: no freq_valid, expected freq=%0d done=%0d", i, e.freq, e.done); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL run_end[%0d]: got freq=%0d done=%0d cyc=%0d, expected freq=%0d done=%0d cyc=%0d", i, o.freq, o.done, o.cyc, e.freq, e.done, e.cyc); end
      end
    end
  endtask

  task automatic test_overrun();
    send(tone(7, {16'sd800, 16'sd800}), 4'd7, 1'b1);
    tick(7);
    send(tone(3, {16'sd2000, 16'sd0}), 4'd3, 1'b0);
    wait_results(1, 40);
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL overrun_result: no freq_valid, expected freq=%0d", e.freq); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL overrun_result: got freq=%0d done=%0d cyc=%0d, expected freq=%0d done=%0d cyc=%0d", o.freq, o.done, o.cyc, e.freq, e.done, e.cyc); end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b, expected 1", overrun); end
    tick(30);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL overrun_dropped: got %0d results for dropped frame, expected 0", obs_q.size()); obs_q.delete(); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b, expected 1", overrun); end
  endtask

  task automatic test_reset_mid_scan();
    send(tone(9, {16'sd600, 16'sd0}), 4'd9, 1'b0);
    tick(7);
    rst = 1'b1;
    #1;
    checks++; if (freq !== 4'd0)       begin errors++; $display("FAIL midscan_freq: got %0d, expected 0", freq); end
    checks++; if (freq_valid !== 1'b0) begin errors++; $display("FAIL midscan_freq_valid: got %b, expected 0", freq_valid); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL midscan_overrun: got %b, expected 0", overrun); end
    tick(2);
    rst = 1'b0;
    res_cnt = 0;
    tick(25);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midscan_no_result: got %0d results, expected 0", obs_q.size()); obs_q.delete(); end
    send(tone(11, {-16'sd50, -16'sd60}), 4'd11, 1'b1);
    wait_results(1, 40);
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL midscan_next: no freq_valid, expected freq=%0d", e.freq); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL midscan_next: got freq=%0d done=%0d cyc=%0d, expected freq=%0d done=%0d cyc=%0d", o.freq, o.done, o.cyc, e.freq, e.done, e.cyc); end
    end
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_tie();
    test_back_to_back();
    test_run_end();
    test_overrun();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Consumes one 16-bin FFT frame per `fft_valid` pulse from the upstream 16-point FFT stage.
- Computes the magnitude of each bin and reports the index of the strongest bin as `freq`, with a `freq_valid` pulse.
- Counts frames and raises `done` after the last frame of a run.
- Sits directly downstream of the FFT and drives the top-level `freq`/`done` outputs.

Parameters:
- FRAMES, 64: frames per run (1024 samples / 16); `done` accompanies result number FRAMES.
- MAG_W, 33: unsigned magnitude width (squared mode).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fft_valid  in  1  one-cycle pulse; `fft_d0..fft_d15` are valid in this cycle
- fft_d0..fft_d15  in  32 each, signed  bin k; [31:16] = real, [15:0] = imag, both signed two's complement
- freq  out  4  index of peak bin of last completed frame
- freq_valid  out  1  one-cycle pulse; `freq` updated
- done  out  1  one-cycle pulse coincident with the FRAMES-th `freq_valid`
- overrun  out  1  sticky; set when a frame was dropped

Behaviour:
- Reset values: freq=0, freq_valid=0, done=0, overrun=0, state=IDLE, bin index=0, frame count=0, max=0, buffer cleared.
- Capture: on a cycle with `fft_valid`=1 that is accepted, all 16 words are registered into a 16x32 buffer. State goes to SCAN with idx=0.
- States:
  - IDLE: on `fft_valid`, capture and go to SCAN.
  - SCAN: one bin per cycle, idx 0..15.
    - mag = re*re + im*im, unsigned MAG_W bits, computed combinationally from buffer[idx].
    - idx=0: max<=mag, arg<=0 unconditionally.
    - idx>0: update only if mag > max (strict). Ties keep the lowest index.
    - On idx=15 the final compare is folded in: freq<=final arg, freq_valid<=1 next cycle.
    - With no new `fft_valid`, return to IDLE.
- Latency: `fft_valid` in cycle 0, scan in cycles 1..16, `freq_valid` high in cycle 17.
- Back-to-back frames: `fft_valid` during the idx=15 cycle is accepted.
  - The buffer reloads at that edge; bin 15 of the old frame is read before the overwrite.
  - State stays SCAN with idx=0. The old result is still emitted.
  - Sustained 16-cycle frame spacing is therefore lossless.
- Overrun: `fft_valid` during SCAN with idx<15 is ignored (scan continues on the old frame) and sets `overrun`. `overrun` clears only on rst.
- Frame counter: increments on each `freq_valid`.
  - When it reaches FRAMES, `done`=1 for that cycle and the counter wraps to 0.
  - A new run needs no reset.
- Reset mid-scan: all state returns to reset values immediately; no `freq_valid` is issued for the interrupted frame.
- `fft_valid` in the same cycle as `freq_valid`/`done`: legal, handled as above.

Optional Feature:
- Macro: FFT_PEAK_MAG_ABS_EN.
- Defined: mag = |re| + |im|, 17-bit unsigned. MAG_W is ignored and the multipliers are removed.
- Undefined: squared magnitude as above.
- Ties, latency, and all handshakes are identical in both modes.

Decomposition:
- Shared package fft_pkg:
  - N_BINS=16, BIN_IDX_W=4, DATA_W=32, RE_MSB=31, RE_LSB=16, IM_MSB=15, IM_LSB=0
  - state encoding IDLE=1'b0, SCAN=1'b1
  - default FRAMES=64
- One sub-module: fft_bin_mag, purely combinational. Input is a 32-bit word, output is the magnitude; the FFT_PEAK_MAG_ABS_EN selection lives there.

Test Plan:
- Single tone: bin 5 = {16'sd1000, 16'sd0}, others 0, `fft_valid` at cycle 0 -> `freq_valid` at cycle 17 with freq=5.
- Negative and tie values: bin 3 = {-16'sd300, 16'sd400}, bin 9 = {16'sd500, 16'sd0} (both mag 250000), others small -> freq=3. In ABS mode, same stimulus gives 700 vs 500 -> freq=3.
- Back-to-back frames: `fft_valid` every 16 cycles with peaks at bins 2, 15, 0 -> three `freq_valid` pulses at cycles 17, 33, 49 with freq 2, 15, 0; overrun=0.
- Overrun: second `fft_valid` 8 cycles after the first -> one result for frame 1 only, overrun=1 and stays 1.
- Run end with FRAMES=4: four frames at 16-cycle spacing -> `done` high only with the 4th `freq_valid`. A 5th frame gives `freq_valid` with done=0 (counter wrapped).
- Reset mid-scan: rst asserted at cycle 8 of a scan -> freq=0, freq_valid never pulses for that frame; the next frame after release is processed normally.
